// File: rtl/mfp_ahb_audio_cmd_master.sv
// AHB-Lite initiator: queues sound commands and turns each into a bus write to the
// audio peripheral. Auto-channel plays first read STATUS to find a free channel.
module mfp_ahb_audio_cmd_master #(
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [31:0] BASE_ADDR   = 32'h1F30_0000,
   parameter logic [3:0]  SOUNDFX_OFF = 4'h0,
   parameter logic [3:0]  STATUS_OFF  = 4'h8
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [4:0]  req_sfx,
   input  logic [3:0]  req_chmask,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP,
   output logic        busy,
   output logic        done_pulse,
   output logic        drop_pulse,
   output logic        err_pulse
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [1:0] OP_PLAY   = 2'd0;
   localparam logic [1:0] OP_STOP   = 2'd1;
   localparam logic [1:0] OP_PAUSE  = 2'd2;
   localparam logic [1:0] OP_RESUME = 2'd3;
   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [31:0] ADDR_SFX  = BASE_ADDR + {28'd0, SOUNDFX_OFF};
   localparam logic [31:0] ADDR_STAT = BASE_ADDR + {28'd0, STATUS_OFF};

   typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_A, WR_D} state_t;
   state_t state;

   logic [10:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          ready_q;
   logic          full, push, pop;
   logic [1:0]    head_op;
   logic [4:0]    head_sfx;
   logic [3:0]    head_mask, cmd_mask, rd_free, rd_low;
   logic [27:0]   unused_rdata;

   function automatic logic [31:0] fmt_wdata(input logic [1:0] op, input logic [4:0] sfx,
                                             input logic [3:0] m);
      fmt_wdata = '0;
      case (op)
         OP_PLAY:   fmt_wdata = {m, 23'd0, sfx};
         OP_STOP:   fmt_wdata[3:0] = m;
         OP_RESUME: fmt_wdata[7:4] = m;
         OP_PAUSE:  fmt_wdata[11:8] = m;
         default:   fmt_wdata = '0;
      endcase
   endfunction

   assign full      = (count == (AW+1)'(FIFO_DEPTH));
   assign req_ready = ready_q && !full;
   assign push      = req_valid && req_ready;
   assign {head_op, head_sfx, head_mask} = mem[rd_ptr];
   assign rd_free      = HRDATA[3:0];
   assign rd_low       = rd_free & 4'(~rd_free + 4'd1);
   assign unused_rdata = HRDATA[31:4];
   assign HSIZE        = 3'b010;
   assign busy         = (state != IDLE) || (count != '0);

   // A command leaves the FIFO on the same edge it finishes (done, drop or error).
   assign pop = ((state == WR_D) && (HRESP || HREADY)) ||
                ((state == RD_D) && (HRESP || (HREADY && rd_free == 4'd0)));

   always_ff @(posedge HCLK) begin
      if (push) mem[wr_ptr] <= {req_op, req_sfx, req_chmask};
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ready_q <= 1'b0;
      end else begin
         ready_q <= 1'b1;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state      <= IDLE;
         HADDR      <= '0;
         HTRANS     <= TR_IDLE;
         HWRITE     <= 1'b0;
         HWDATA     <= '0;
         cmd_mask   <= '0;
         done_pulse <= 1'b0;
         drop_pulse <= 1'b0;
         err_pulse  <= 1'b0;
      end else begin
         done_pulse <= 1'b0;
         drop_pulse <= 1'b0;
         err_pulse  <= 1'b0;
         case (state)
            IDLE: if (count != '0) begin
               cmd_mask <= head_mask;
               HTRANS   <= TR_NONSEQ;
               if (head_op == OP_PLAY && head_mask == 4'd0) begin
                  state  <= RD_A;
                  HADDR  <= ADDR_STAT;
                  HWRITE <= 1'b0;
               end else begin
                  state  <= WR_A;
                  HADDR  <= (head_op == OP_PLAY) ? ADDR_SFX : ADDR_STAT;
                  HWRITE <= 1'b1;
               end
            end
            RD_A: if (HREADY) begin
               HTRANS <= TR_IDLE;
               state  <= RD_D;
            end
            RD_D: if (HRESP) begin
               err_pulse <= 1'b1;
               state     <= IDLE;
            end else if (HREADY) begin
               if (rd_free == 4'd0) begin
                  drop_pulse <= 1'b1;
                  state      <= IDLE;
               end else begin
                  cmd_mask <= rd_low;
                  HTRANS   <= TR_NONSEQ;
                  HADDR    <= ADDR_SFX;
                  HWRITE   <= 1'b1;
                  state    <= WR_A;
               end
            end
            WR_A: if (HREADY) begin
               HTRANS <= TR_IDLE;
               HWDATA <= fmt_wdata(head_op, head_sfx, cmd_mask);
               state  <= WR_D;
            end
            WR_D: if (HRESP) begin
               err_pulse <= 1'b1;
               state     <= IDLE;
            end else if (HREADY) begin
               done_pulse <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mfp_ahb_audio_cmd_master.sv
// Directed bench for mfp_ahb_audio_cmd_master: command formats, auto channel pick,
// drop, FIFO back-pressure with bus stall, error response and mid-transfer reset.
module tb_mfp_ahb_audio_cmd_master;
   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = '0;
   logic [4:0]  req_sfx = '0;
   logic [3:0]  req_chmask = '0;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA = '0;
   logic        HREADY = 1'b1;
   logic        HRESP = 1'b0;
   logic        busy, done_pulse, drop_pulse, err_pulse;

   int checks = 0;
   int failures = 0;

   mfp_ahb_audio_cmd_master dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_sfx(req_sfx), .req_chmask(req_chmask),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .busy(busy),
      .done_pulse(done_pulse), .drop_pulse(drop_pulse), .err_pulse(err_pulse)
   );

   always #5 HCLK = ~HCLK;

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic set_req(input logic v, input logic [1:0] op, input logic [4:0] sfx,
                          input logic [3:0] m);
      req_valid = v; req_op = op; req_sfx = sfx; req_chmask = m;
   endtask

   task automatic test_reset();
      tick(); tick();
      checks++;
      if (HSIZE !== 3'b010 || HTRANS !== 2'b00 || HADDR !== 32'h0 || HWRITE !== 1'b0 ||
          HWDATA !== 32'h0 || busy !== 1'b0 || req_ready !== 1'b0 || done_pulse !== 1'b0 ||
          drop_pulse !== 1'b0 || err_pulse !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: HSIZE=%b HTRANS=%b HADDR=%h HWRITE=%b rdy=%b busy=%b, need 010/00/0/0/0/0",
                  HSIZE, HTRANS, HADDR, HWRITE, req_ready, busy);
      end
      #3 HRESETn = 1'b1;
      tick();
      checks++;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_release: req_ready=%b busy=%b, need 1/0", req_ready, busy);
      end
   endtask

   task automatic test_play();
      set_req(1, 2'd0, 5'd5, 4'b0011);
      tick();
      set_req(0, 0, 0, 0);
      tick();
      checks++;
      if (HTRANS !== 2'b10 || HADDR !== 32'h1F30_0000 || HWRITE !== 1'b1) begin
         failures++;
         $display("FAIL play_addr: HTRANS=%b HADDR=%h HWRITE=%b, need 10/1F300000/1", HTRANS, HADDR, HWRITE);
      end
      tick();
      checks++;
      if (HTRANS !== 2'b00 || HWDATA !== 32'h3000_0005) begin
         failures++;
         $display("FAIL play_data: HTRANS=%b HWDATA=%h, need 00/30000005", HTRANS, HWDATA);
      end
      tick();
      checks++;
      if (done_pulse !== 1'b1) begin
         failures++;
         $display("FAIL play_done_latency: done_pulse=%b, need 1", done_pulse);
      end
      tick();
      checks++;
      if (done_pulse !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL play_done_width: done_pulse=%b busy=%b, need 0/0", done_pulse, busy);
      end
   endtask

   task automatic test_auto_play();
      set_req(1, 2'd0, 5'd2, 4'b0000);
      tick();
      set_req(0, 0, 0, 0);
      HRDATA = 32'h0000_00C6;
      tick();
      checks++;
      if (HTRANS !== 2'b10 || HADDR !== 32'h1F30_0008 || HWRITE !== 1'b0) begin
         failures++;
         $display("FAIL auto_read_addr: HTRANS=%b HADDR=%h HWRITE=%b, need 10/1F300008/0", HTRANS, HADDR, HWRITE);
      end
      tick();
      tick();
      checks++;
      if (HTRANS !== 2'b10 || HADDR !== 32'h1F30_0000 || HWRITE !== 1'b1) begin
         failures++;
         $display("FAIL auto_write_addr: HTRANS=%b HADDR=%h HWRITE=%b, need 10/1F300000/1", HTRANS, HADDR, HWRITE);
      end
      tick();
      checks++;
      if (HWDATA !== 32'h2000_0002) begin
         failures++;
         $display("FAIL auto_write_data: HWDATA=%h, need 20000002", HWDATA);
      end
      tick();
      checks++;
      if (done_pulse !== 1'b1) begin
         failures++;
         $display("FAIL auto_done: done_pulse=%b, need 1", done_pulse);
      end
      HRDATA = '0;
      tick();
   endtask

   task automatic test_auto_drop();
      int writes;
      set_req(1, 2'd0, 5'd9, 4'b0000);
      tick();
      set_req(0, 0, 0, 0);
      HRDATA = 32'h0000_00F0;
      tick(); tick(); tick();
      checks++;
      if (drop_pulse !== 1'b1 || done_pulse !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL auto_drop: drop=%b done=%b busy=%b rdy=%b, need 1/0/0/1", drop_pulse, done_pulse, busy, req_ready);
      end
      writes = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (HTRANS == 2'b10) writes++;
      end
      checks++;
      if (writes !== 0) begin
         failures++;
         $display("FAIL auto_drop_no_write: transfers=%0d, need 0", writes);
      end
      HRDATA = '0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] addr_seen [4];
      logic [31:0] data_seen [4];
      int n;
      logic pend;
      n = 0; pend = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (c == 0)      set_req(1, 2'd2, 5'd0, 4'b1000);
         else if (c == 1) set_req(1, 2'd3, 5'd0, 4'b1000);
         else             set_req(0, 0, 0, 0);
         tick();
         if (pend && n < 4) begin data_seen[n] = HWDATA; n++; pend = 1'b0; end
         if (HTRANS == 2'b10 && HWRITE && n < 4) begin addr_seen[n] = HADDR; pend = 1'b1; end
      end
      checks++;
      if (n !== 2) begin
         failures++;
         $display("FAIL b2b_count: writes=%0d, need 2", n);
      end else begin
         checks++;
         if (addr_seen[0] !== 32'h1F30_0008 || data_seen[0] !== 32'h0000_0800) begin
            failures++;
            $display("FAIL b2b_pause: addr=%h data=%h, need 1F300008/00000800", addr_seen[0], data_seen[0]);
         end
         checks++;
         if (addr_seen[1] !== 32'h1F30_0008 || data_seen[1] !== 32'h0000_0080) begin
            failures++;
            $display("FAIL b2b_resume: addr=%h data=%h, need 1F300008/00000080", addr_seen[1], data_seen[1]);
         end
      end
   endtask

   task automatic test_fifo_full_stall();
      logic [31:0] exp_data [4];
      logic [31:0] data_seen [8];
      logic [3:0] masks [5];
      int n;
      logic pend;
      masks[0] = 4'h1; masks[1] = 4'h2; masks[2] = 4'h4; masks[3] = 4'h8; masks[4] = 4'hF;
      exp_data[0] = 32'h1; exp_data[1] = 32'h2; exp_data[2] = 32'h4; exp_data[3] = 32'h8;
      HREADY = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (req_ready !== (i < 4)) begin
            failures++;
            $display("FAIL full_ready_%0d: req_ready=%b, need %b", i, req_ready, (i < 4));
         end
         set_req(1, 2'd1, 5'd0, masks[i]);
         tick();
      end
      set_req(0, 0, 0, 0);
      tick(); tick();
      checks++;
      if (HTRANS !== 2'b10 || HADDR !== 32'h1F30_0008 || HWRITE !== 1'b1) begin
         failures++;
         $display("FAIL stall_frozen: HTRANS=%b HADDR=%h HWRITE=%b, need 10/1F300008/1", HTRANS, HADDR, HWRITE);
      end
      HREADY = 1'b1;
      n = 0; pend = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (pend && n < 8) begin data_seen[n] = HWDATA; n++; pend = 1'b0; end
         if (HTRANS == 2'b10 && HWRITE) pend = 1'b1;
         tick();
      end
      checks++;
      if (n !== 4) begin
         failures++;
         $display("FAIL stall_write_count: writes=%0d, need 4", n);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (data_seen[i] !== exp_data[i]) begin
               failures++;
               $display("FAIL stall_order_%0d: HWDATA=%h, need %h", i, data_seen[i], exp_data[i]);
            end
         end
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL stall_drain: busy=%b, need 0", busy);
      end
   endtask

   task automatic test_error();
      set_req(1, 2'd1, 5'd0, 4'b0001);
      tick();
      set_req(1, 2'd3, 5'd0, 4'b0010);
      tick();
      set_req(0, 0, 0, 0);
      tick();
      HRESP = 1'b1;
      tick();
      HRESP = 1'b0;
      checks++;
      if (err_pulse !== 1'b1 || done_pulse !== 1'b0) begin
         failures++;
         $display("FAIL err_pulse: err=%b done=%b, need 1/0", err_pulse, done_pulse);
      end
      tick();
      checks++;
      if (HTRANS !== 2'b10 || HADDR !== 32'h1F30_0008 || err_pulse !== 1'b0) begin
         failures++;
         $display("FAIL err_next_addr: HTRANS=%b HADDR=%h err=%b, need 10/1F300008/0", HTRANS, HADDR, err_pulse);
      end
      tick();
      checks++;
      if (HWDATA !== 32'h0000_0020) begin
         failures++;
         $display("FAIL err_next_data: HWDATA=%h, need 00000020", HWDATA);
      end
      tick();
      checks++;
      if (done_pulse !== 1'b1) begin
         failures++;
         $display("FAIL err_next_done: done_pulse=%b, need 1", done_pulse);
      end
      tick();
   endtask

   task automatic test_reset_mid_transfer();
      int writes;
      set_req(1, 2'd2, 5'd0, 4'b0100);
      tick();
      set_req(1, 2'd1, 5'd0, 4'b0100);
      tick();
      set_req(0, 0, 0, 0);
      HREADY = 1'b0;
      tick();
      HREADY = 1'b1;
      tick();
      HREADY = 1'b0;
      tick();
      HRESETn = 1'b0;
      #1;
      checks++;
      if (HTRANS !== 2'b00 || busy !== 1'b0 || done_pulse !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid: HTRANS=%b busy=%b done=%b, need 00/0/0", HTRANS, busy, done_pulse);
      end
      #2 HRESETn = 1'b1;
      HREADY = 1'b1;
      writes = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (HTRANS == 2'b10) writes++;
      end
      checks++;
      if (writes !== 0 || busy !== 1'b0 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_fifo_empty: transfers=%0d busy=%b rdy=%b, need 0/0/1", writes, busy, req_ready);
      end
   endtask

   initial begin
      test_reset();
      test_play();
      test_auto_play();
      test_auto_drop();
      test_back_to_back();
      test_fifo_full_stall();
      test_error();
      test_reset_mid_transfer();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
